// File: rtl/tiny_rv_fetch_queue.sv
// tiny_rv_fetch_queue: in-order instruction prefetch front-end for the tiny_rv core.
// Latency: redirect at t -> request t+1 -> (1-cycle imem) o_fetched_valid at t+3; 1 inst/cycle steady state.
// Backpressure: decode ready=0 fills the queue, then credit (queued+outstanding<FIFO_DEPTH) drops o_imem_req.
//
// Ports:
//   i_clk, i_reset                       clock, synchronous active-high reset
//   i_pipe_flush                         empty queue, drop in-flight reads, park in HOLD
//   i_ld_new_addr, i_new_addr            redirect: empty queue, drop in-flight reads, fetch from target
//   o_imem_req, o_imem_addr, i_imem_gnt  request channel (req&&gnt = issued), word address
//   i_imem_rvalid, i_imem_rdata          in-order read responses
//   o_fetched_valid, i_fetched_ready     head of prefetch queue to decode (valid&&ready = pop)
//   o_fetched_pc, o_fetched_inst         head entry, forced to zero while the queue is empty
//   o_misaligned                         1-cycle pulse after a redirect to a non-word-aligned target

module tiny_rv_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IMEM_AW    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pipe_flush,
  input  logic               i_ld_new_addr,
  input  logic [31:0]        i_new_addr,
  output logic               o_imem_req,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [31:0]        i_imem_rdata,
  output logic               o_fetched_valid,
  input  logic               i_fetched_ready,
  output logic [31:0]        o_fetched_pc,
  output logic [31:0]        o_fetched_inst,
  output logic               o_misaligned
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_Q = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding, outstanding_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] q_count, tag_count;
  logic [CW:0]   inflight;
  logic          restart, imem_req, issue, resp_keep, q_pop;
  logic [31:0]   tag_pc;
  entry_t        q_in, q_out;

  // Redirect and flush share all the "throw away in-flight work" behaviour.
  assign restart  = i_ld_new_addr || i_pipe_flush;
  // Credit counts every outstanding read, including ones that will be dropped,
  // so a queue slot is reserved for anything that could still come back.
  assign inflight = {1'b0, q_count} + {1'b0, outstanding};

  // FSM: next state and request generation.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    if (state_q == RUN) begin
      if (i_pipe_flush && !i_ld_new_addr) state_d = HOLD;
      if (!restart && !i_reset) imem_req = (inflight < DEPTH_C);
    end else if (i_ld_new_addr) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= RUN;
    else         state_q <= state_d;
  end

  assign o_imem_req  = imem_req;
  assign o_imem_addr = fetch_pc[IMEM_AW+1:2];
  assign issue       = imem_req && i_imem_gnt;

  // A response is kept only when no stale reads are ahead of it and no
  // redirect/flush is discarding the current cycle's data.
  assign resp_keep = i_imem_rvalid && (drop == '0) && !restart;
  assign q_pop     = o_fetched_valid && i_fetched_ready;

  assign outstanding_next = outstanding
                          + {{(CW-1){1'b0}}, issue}
                          - {{(CW-1){1'b0}}, i_imem_rvalid};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_pc     <= RESET_PC;
      outstanding  <= '0;
      drop         <= '0;
      o_misaligned <= 1'b0;
    end else begin
      outstanding  <= outstanding_next;
      o_misaligned <= i_ld_new_addr && (i_new_addr[1:0] != 2'b00);
      if (i_ld_new_addr)  fetch_pc <= {i_new_addr[31:2], 2'b00};
      else if (issue)     fetch_pc <= fetch_pc + 32'd4;
      // Everything still in flight after this edge belongs to the old stream.
      if (restart)                       drop <= outstanding_next;
      else if (i_imem_rvalid && drop != '0) drop <= drop - ONE_C;
    end
  end

  // PC of each live request, consumed in issue order by kept responses.
  tiny_rv_fetch_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk      (i_clk),
    .reset    (i_reset),
    .clr      (restart),
    .push     (issue),
    .push_dat (fetch_pc),
    .pop      (resp_keep),
    .pop_dat  (tag_pc),
    .count    (tag_count)
  );

  assign q_in = '{pc: tag_pc, inst: i_imem_rdata};

  tiny_rv_fetch_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
    .clk      (i_clk),
    .reset    (i_reset),
    .clr      (restart),
    .push     (resp_keep),
    .push_dat (q_in),
    .pop      (q_pop),
    .pop_dat  (q_out),
    .count    (q_count)
  );

  assign o_fetched_valid = (q_count != '0);
  assign o_fetched_pc    = o_fetched_valid ? q_out.pc   : 32'h0;
  assign o_fetched_inst  = o_fetched_valid ? q_out.inst : 32'h0;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(resp_keep && q_count == DEPTH_Q && !q_pop));
  a_rvalid_expected: assert property (@(posedge i_clk) disable iff (i_reset)
    i_imem_rvalid |-> (outstanding != '0));
  a_tag_tracking: assert property (@(posedge i_clk) disable iff (i_reset)
    (tag_count + drop) == outstanding);

endmodule

// tiny_rv_fetch_fifo: generic synchronous FIFO with clear, power-of-2 depth.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: none internal; caller never pushes when full (unless popping) nor pops when empty.
//
// Ports: clk, reset (sync, active-high), clr (sync flush), push/push_dat,
//        pop/pop_dat (head word), count (current occupancy 0..DEPTH).

module tiny_rv_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !(reset || clr)) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];

endmodule

// File: tb/tb_tiny_rv_fetch_queue.sv
// Bench for tiny_rv_fetch_queue: table-driven reset/redirect vectors, hand-written
// back-pressure / drop / flush sequences, and randomized traffic against a
// stream-level model (epoch-tagged reads, expected delivery queue).

module tb_tiny_rv_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, ld;
  logic [31:0] naddr;
  logic        req;
  logic [15:0] addr;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        vld, rdy;
  logic [31:0] pc, inst;
  logic        mis;

  tiny_rv_fetch_queue #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .IMEM_AW(16)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_pipe_flush    (flush),
    .i_ld_new_addr   (ld),
    .i_new_addr      (naddr),
    .o_imem_req      (req),
    .o_imem_addr     (addr),
    .i_imem_gnt      (gnt),
    .i_imem_rvalid   (rvalid),
    .i_imem_rdata    (rdata),
    .o_fetched_valid (vld),
    .i_fetched_ready (rdy),
    .o_fetched_pc    (pc),
    .o_fetched_inst  (inst),
    .o_misaligned    (mis)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [15:0] wa);
    return {~wa, wa} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- imem + reference model ----------------
  typedef struct {
    logic [15:0] waddr;
    logic [31:0] pc;
    int          epoch;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  pend_t       pend[$];   // reads issued to imem and not yet answered
  ent_t        mq[$];     // what decode should see, in order
  logic [31:0] mfpc;      // next expected fetch byte address
  int          epoch, cyc, lat, dropped, grants, pops;
  logic        hold, exp_mis;
  int unsigned gnt_pct, rv_pct;

  logic        s_req, s_vld, s_mis;
  logic [15:0] s_addr;
  logic [31:0] s_pc, s_inst;

  // One clock cycle: entered just after a negedge with flush/ld/naddr/rdy set.
  task automatic tick();
    pend_t pe;
    ent_t  ne;
    logic  rst;
    int    occ;
    rvalid = 1'b0;
    rdata  = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 99) < rv_pct) begin
      rvalid = 1'b1;
      rdata  = memf(pend[0].waddr);
    end
    gnt = ($urandom_range(0, 99) < gnt_pct);
    #1;
    s_req = req; s_addr = addr; s_vld = vld; s_pc = pc; s_inst = inst; s_mis = mis;
    rst = ld || flush;
    occ = mq.size() + pend.size();
    chk("req", s_req, !hold && !rst && (occ < DEPTH));
    if (s_req && gnt) chk("addr", s_addr, mfpc[17:2]);
    chk("valid", s_vld, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("head_pc", s_pc, mq[0].pc);
      chk("head_inst", s_inst, mq[0].inst);
    end
    chk("misaligned", s_mis, exp_mis);
    chk("credit", occ <= DEPTH, 1);
    @(posedge clk);
    if (mq.size() != 0 && rdy) begin
      void'(mq.pop_front());
      pops++;
    end
    if (rvalid) begin
      pe = pend.pop_front();
      if (!rst && pe.epoch == epoch) begin
        ne.pc   = pe.pc;
        ne.inst = memf(pe.pc[17:2]);
        mq.push_back(ne);
      end else begin
        dropped++;
      end
    end
    if (s_req && gnt) begin
      pe.waddr = s_addr; pe.pc = mfpc; pe.epoch = epoch; pe.due = cyc + lat;
      pend.push_back(pe);
      mfpc = mfpc + 32'd4;
      grants++;
    end
    exp_mis = ld && (naddr[1:0] != 2'b00);
    if (ld) begin
      epoch++; mq.delete(); mfpc = {naddr[31:2], 2'b00}; hold = 1'b0;
    end else if (flush) begin
      epoch++; mq.delete(); hold = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; ld = 1'b0; naddr = 32'h0; rdy = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_valid", vld, 0);
    chk("rst_pc", pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_mis", mis, 0);
    pend.delete(); mq.delete();
    mfpc = 32'h0; hold = 1'b0; exp_mis = 1'b0; epoch++; cyc = 0;
    reset = 1'b0;
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic        flush;
    logic        ld;
    logic [31:0] naddr;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t        tbl [9];
  logic [31:0] seen[$];
  int          n;
  int          r;

  initial begin
    epoch = 0; dropped = 0; grants = 0; pops = 0; lat = 1;
    gnt_pct = 100; rv_pct = 100;

    // Reset, gnt=1, 1-cycle imem, ready=1; redirect to misaligned 0x102 in row 4.
    tbl[0] = '{1'b0, 1'b0, 32'h0,   1'b1, 16'h0000, 1'b0, 32'h0,   1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h0,   1'b1, 16'h0001, 1'b0, 32'h0,   1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,   1'b1, 16'h0002, 1'b1, 32'h0,   1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,   1'b1, 16'h0003, 1'b1, 32'h4,   1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h102, 1'b0, 16'h0000, 1'b1, 32'h8,   1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,   1'b1, 16'h0040, 1'b0, 32'h0,   1'b1};
    tbl[6] = '{1'b0, 1'b0, 32'h0,   1'b1, 16'h0041, 1'b0, 32'h0,   1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h0,   1'b1, 16'h0042, 1'b1, 32'h100, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 32'h0,   1'b1, 16'h0043, 1'b1, 32'h104, 1'b0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      flush = tbl[i].flush; ld = tbl[i].ld; naddr = tbl[i].naddr; rdy = 1'b1;
      tick();
      chk($sformatf("t%0d_req", i), s_req, tbl[i].exp_req);
      if (tbl[i].exp_req) chk($sformatf("t%0d_addr", i), s_addr, tbl[i].exp_addr);
      chk($sformatf("t%0d_vld", i), s_vld, tbl[i].exp_vld);
      if (tbl[i].exp_vld) chk($sformatf("t%0d_pc", i), s_pc, tbl[i].exp_pc);
      chk($sformatf("t%0d_mis", i), s_mis, tbl[i].exp_mis);
    end
    ld = 1'b0;

    // Back-pressure: ready=0 for 10 cycles -> exactly DEPTH grants, then drain in order.
    do_reset();
    grants = 0; rdy = 1'b0;
    repeat (10) tick();
    chk("bp_grants", grants, DEPTH);
    chk("bp_req_off", s_req, 0);
    chk("bp_head_pc", s_pc, 32'h0);
    rdy = 1'b1;
    seen.delete();
    n = 0;
    while (seen.size() < 6 && n < 30) begin
      tick();
      if (s_vld) seen.push_back(s_pc);
      n++;
    end
    chk("bp_drained", seen.size(), 6);
    for (int i = 0; i < seen.size(); i++) chk($sformatf("bp_order%0d", i), seen[i], 32'(i * 4));

    // Latency-3 imem, redirect to 0x100 with 3 reads outstanding.
    do_reset();
    lat = 3; rdy = 1'b1;
    n = 0;
    while (pend.size() != 3 && n < 20) begin tick(); n++; end
    chk("drop_setup", pend.size(), 3);
    r = dropped;
    ld = 1'b1; naddr = 32'h100;
    tick();
    ld = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!s_vld && n < 20);
    chk("drop_valid", s_vld, 1);
    chk("drop_count", dropped - r, 3);
    chk("drop_pc", s_pc, 32'h100);
    chk("drop_inst", s_inst, memf(16'h0040));

    // Flush in RUN -> HOLD with no requests, then redirect to 0x20 resumes.
    do_reset();
    lat = 1; rdy = 1'b1;
    repeat (6) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_vld", s_vld, 0);
    chk("flush_req", s_req, 0);
    n = 0;
    repeat (5) begin tick(); if (s_req) n++; end
    chk("hold_reqs", n, 0);
    ld = 1'b1; naddr = 32'h20;
    tick();
    ld = 1'b0;
    tick();
    chk("resume_req", s_req, 1);
    chk("resume_addr", s_addr, 16'h0008);
    n = 0;
    do begin tick(); n++; end while (!s_vld && n < 10);
    chk("resume_pc", s_pc, 32'h20);

    // Randomized traffic with redirects, flushes and mid-run resets.
    pops = 0;
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      lat = 1 + ph; gnt_pct = 70; rv_pct = 60;
      repeat (1500) begin
        r = $urandom_range(0, 99);
        rdy   = ($urandom_range(0, 99) < 70);
        ld    = (r < 4) || (r == 7);
        flush = (r >= 4 && r <= 7);
        naddr = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'h0003_FFFF);
        tick();
      end
      flush = 1'b0; ld = 1'b0;
    end
    chk("rand_progress", pops > 300, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
